// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 mouse device-side transmitter.
package ps2_pkg;

    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUS,
        ST_BIT_HI,
        ST_BIT_LO,
        ST_INHIBIT
    } ps2_state_t;

    // Parity bit that makes the total count of ones in {data, parity} odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

    // Clip a signed 10-bit motion value to the 9-bit range -256..255.
    // Returns {overflow, clipped[8:0]}.
    function automatic logic [9:0] sat9(input logic signed [9:0] v);
        if (v > 10'sd255)
            return {1'b1, 9'h0FF};
        else if (v < -10'sd256)
            return {1'b1, 9'h100};
        else
            return {1'b0, v[8:0]};
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// One-byte PS/2 device-to-host serialiser. Waits for an idle bus, clocks out
// start/data/parity/stop, and restarts the byte if the host inhibits the clock.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int HALF_CYC = 2000,
    parameter int GAP_CYC  = 2500
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_byte_end,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk,
    output logic       o_ps2_data,
    output logic       o_abort
);

    localparam int CNT_MAX = (GAP_CYC > HALF_CYC) ? GAP_CYC : HALF_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ps2_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [3:0]            r_bit;
    logic [FRAME_BITS-1:0] r_frame;
    logic                  r_clk_out;
    logic                  r_data_out;
    logic                  r_abort;

    logic                  w_half_end;
    logic                  w_gap_end;
    logic                  w_last_lo;
    logic [3:0]            w_next_bit;
    logic [FRAME_BITS-1:0] w_frame;

    assign w_half_end = (r_cnt == CNT_W'(HALF_CYC - 1));
    assign w_gap_end  = (r_cnt == CNT_W'(GAP_CYC - 1));
    assign w_next_bit = r_bit + 4'd1;
    assign w_last_lo  = (r_state == ST_BIT_LO) && (r_bit == 4'(FRAME_BITS - 1)) && w_half_end;
    // Frame sent LSB first: start 0, data, odd parity, stop 1.
    assign w_frame    = {1'b1, odd_parity(i_byte), i_byte, 1'b0};

    // A new byte can be taken while idle or on the very edge the previous stop bit ends,
    // so back-to-back bytes go straight into the bus-idle wait with no dead cycle.
    assign o_ready    = (r_state == ST_IDLE) || w_last_lo;
    assign o_byte_end = w_last_lo;
    assign o_ps2_clk  = r_clk_out;
    assign o_ps2_data = r_data_out;
    assign o_abort    = r_abort;

    // Serialiser state machine with registered line drivers and abort pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_clk_out  <= 1'b1;
            r_data_out <= 1'b1;
            r_abort    <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clk_out  <= 1'b1;
                    r_data_out <= 1'b1;
                    if (i_valid) begin
                        r_frame <= w_frame;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= ST_WAIT_BUS;
                    end
                end
                ST_WAIT_BUS: begin
                    // Both lines must stay high for GAP_CYC consecutive cycles; a host
                    // request-to-send (data low) simply keeps the count at zero.
                    if (i_ps2_clk && i_ps2_data) begin
                        if (w_gap_end) begin
                            r_cnt      <= '0;
                            r_bit      <= '0;
                            r_data_out <= r_frame[0];
                            r_clk_out  <= 1'b1;
                            r_state    <= ST_BIT_HI;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_BIT_HI: begin
                    // Inhibit wins over the half-period expiring on the same cycle.
                    if (!i_ps2_clk) begin
                        r_clk_out  <= 1'b1;
                        r_data_out <= 1'b1;
                        r_abort    <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= ST_INHIBIT;
                    end else if (w_half_end) begin
                        r_clk_out <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= ST_BIT_LO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_BIT_LO: begin
                    if (w_half_end) begin
                        r_cnt     <= '0;
                        r_clk_out <= 1'b1;
                        if (r_bit != 4'(FRAME_BITS - 1)) begin
                            r_bit      <= w_next_bit;
                            r_data_out <= r_frame[w_next_bit];
                            r_state    <= ST_BIT_HI;
                        end else begin
                            r_bit      <= '0;
                            r_data_out <= 1'b1;
                            if (i_valid) begin
                                r_frame <= w_frame;
                                r_state <= ST_WAIT_BUS;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_INHIBIT: begin
                    // The interrupted byte is kept and restarts from its start bit.
                    if (i_ps2_clk) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= ST_WAIT_BUS;
                    end
                end
                default: begin
                    r_clk_out  <= 1'b1;
                    r_data_out <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_mouse_device_tx.sv
// PS/2 mouse device transmitter: accepts a motion/button report, formats the
// standard 3-byte packet and hands the bytes to the frame serialiser in order.
module ps2_mouse_device_tx
    import ps2_pkg::*;
#(
    parameter int HALF_CYC = 2000,
    parameter int GAP_CYC  = 2500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              report_en,
    input  logic              rpt_valid,
    output logic              rpt_ready,
    input  logic signed [9:0] rpt_dx,
    input  logic signed [9:0] rpt_dy,
    input  logic [2:0]        rpt_buttons,
    input  logic              ps2_clk_in,
    input  logic              ps2_data_in,
    output logic              ps2_clk_out,
    output logic              ps2_data_out,
    output logic              busy,
    output logic              pkt_done,
    output logic              tx_abort
);

    logic       r_busy;
    logic       r_rpt_ready;
    logic       r_pkt_done;
    logic [1:0] r_next;
    logic [7:0] r_byte1;
    logic [7:0] r_byte2;

    logic [9:0] w_sat_x;
    logic [9:0] w_sat_y;
    logic [7:0] w_byte0;
    logic       w_accept;
    logic       w_tx_valid;
    logic [7:0] w_tx_byte;
    logic       w_tx_ready;
    logic       w_byte_end;

    assign w_sat_x  = sat9(rpt_dx);
    assign w_sat_y  = sat9(rpt_dy);
    // {yovf, xovf, ysign, xsign, 1, middle, right, left}
    assign w_byte0  = {w_sat_y[9], w_sat_x[9], w_sat_y[8], w_sat_x[8], 1'b1, rpt_buttons};
    assign w_accept = rpt_valid && r_rpt_ready;

    // Byte 0 goes to the serialiser straight from the accepted report; bytes 1 and 2
    // are offered from the latch as each previous byte finishes.
    assign w_tx_valid = w_accept || (r_busy && (r_next != 2'd3));
    assign w_tx_byte  = w_accept ? w_byte0 : ((r_next == 2'd1) ? r_byte1 : r_byte2);

    assign rpt_ready = r_rpt_ready;
    assign busy      = r_busy;
    assign pkt_done  = r_pkt_done;

    ps2_frame_tx #(
        .HALF_CYC (HALF_CYC),
        .GAP_CYC  (GAP_CYC)
    ) u_frame (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_valid    (w_tx_valid),
        .i_byte     (w_tx_byte),
        .o_ready    (w_tx_ready),
        .o_byte_end (w_byte_end),
        .i_ps2_clk  (ps2_clk_in),
        .i_ps2_data (ps2_data_in),
        .o_ps2_clk  (ps2_clk_out),
        .o_ps2_data (ps2_data_out),
        .o_abort    (tx_abort)
    );

    // Report latch, byte sequencing and packet-level handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_rpt_ready <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_next      <= 2'd0;
        end else begin
            r_pkt_done <= 1'b0;
            if (w_accept) begin
                r_busy      <= 1'b1;
                r_rpt_ready <= 1'b0;
                r_next      <= 2'd1;
                r_byte1     <= w_sat_x[7:0];
                r_byte2     <= w_sat_y[7:0];
            end else if (r_busy && w_byte_end && w_tx_ready) begin
                if (r_next == 2'd3) begin
                    r_busy      <= 1'b0;
                    r_pkt_done  <= 1'b1;
                    r_rpt_ready <= report_en;
                end else begin
                    r_next <= r_next + 2'd1;
                end
            end else begin
                r_rpt_ready <= report_en && !r_busy;
            end
        end
    end

endmodule
